// File: rtl/param_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, with sign-magnitude handling of signed operands.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module param_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, nextstate;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    accnext;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic             sgn;
  logic             finish;

  // Signed operands are reduced to magnitudes; the most-negative value maps to 2^(WIDTH-1).
  assign amag    = (signed_mode && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign bmag    = (signed_mode && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
  assign accnext = acc + (mplier[0] ? mcand : {PW{1'b0}});

`ifdef MULT_EARLY_TERM_EN
  assign finish = (mplier[WIDTH-1:1] == '0);
`else
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == CALC)
      cnt <= cnt + CW'(1);
    else
      cnt <= '0;
  end

  assign finish = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextstate;
  end

  always_comb begin
    nextstate = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start)
          nextstate = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (finish)
          nextstate = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextstate = IDLE;
      end
      default: nextstate = IDLE;
    endcase
  end

  // Product only moves on the final CALC edge, so it holds steady between results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      sgn     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, amag};
            mplier <= bmag;
            acc    <= '0;
            sgn    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc    <= accnext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (finish)
            product <= sgn ? (PW'(0) - accnext) : accnext;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_multiplier.sv
// Bench for param_multiplier: directed WIDTH=8 cases plus randomized WIDTH=4/16 sweeps against an arithmetic model.
module tb_param_multiplier;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic rst2;

  logic        start8, sm8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        start4, sm4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  logic        start16, sm16, ready16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int checks = 0;
  int failures = 0;
  int n4 = 0;
  int n16 = 0;
  bit sweepDone = 1'b0;
  logic [63:0] q4[$];
  logic [63:0] q16[$];

  always #5 clock = ~clock;

  param_multiplier #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8));

  param_multiplier #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(rst2), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4));

  param_multiplier #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(rst2), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16));

  // Exact product from ordinary integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input bit sm, input int w);
    longint mask, xv, yv, pmask;
    mask  = (longint'(1) << w) - 1;
    pmask = (longint'(1) << (2 * w)) - 1;
    xv = longint'(x) & mask;
    yv = longint'(y) & mask;
    if (sm && x[w-1]) xv = xv - (longint'(1) << w);
    if (sm && y[w-1]) yv = yv - (longint'(1) << w);
    return 64'((xv * yv) & pmask);
  endfunction

  // Edges from accept to the done cycle, counting the accepting edge as one.
  function automatic int refLatency(input logic [31:0] y, input bit sm, input int w);
    longint mag;
    int p;
    mag = longint'(y) & ((longint'(1) << w) - 1);
    if (sm && y[w-1]) mag = (longint'(1) << w) - mag;
    p = 0;
    for (int i = 0; i < w; i++)
      if (mag[i]) p = i;
    return EARLY ? (p + 2) : (w + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                               input bit sm, input logic [15:0] expp, input bit pulse);
    int n;
    int busyCnt;
    int lat;
    logic [15:0] prev;
    lat = refLatency(32'(tb), sm, 8);
    @(negedge clock);
    checkOutput({tag, " ready"}, 64'(ready8), 64'd1);
    prev = product8;
    a8 = ta; b8 = tb; sm8 = sm; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    n = 0;
    busyCnt = 0;
    while (!done8 && n < 40) begin
      if (busy8) busyCnt++;
      if (n == 2) checkOutput({tag, " hold"}, 64'(product8), 64'(prev));
      start8 = pulse && (n == 3);
      @(negedge clock);
      n++;
    end
    start8 = 1'b0;
    checkOutput({tag, " lat"}, 64'(n + 1), 64'(lat));
    checkOutput({tag, " prod"}, 64'(product8), 64'(expp));
    checkOutput({tag, " busy"}, 64'(busyCnt), 64'(lat - 1));
    checkOutput({tag, " flags"}, 64'({ready8, busy8}), 64'd0);
    @(negedge clock);
    checkOutput({tag, " idle"}, 64'({done8, ready8}), 64'd1);
    checkOutput({tag, " keep"}, 64'(product8), 64'(expp));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sm;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10] = '{
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'h80, 8'h80, 1'b1, 16'h4000},
    '{8'hFD, 8'h05, 1'b1, 16'hFFF1},
    '{8'h07, 8'h03, 1'b0, 16'h0015},
    '{8'hF3, 8'h00, 1'b1, 16'h0000},
    '{8'h80, 8'h7F, 1'b1, 16'hC080},
    '{8'h7F, 8'hFF, 1'b1, 16'hFF81},
    '{8'h80, 8'hFF, 1'b1, 16'h0080},
    '{8'h00, 8'h00, 1'b0, 16'h0000},
    '{8'h80, 8'h02, 1'b0, 16'h0100}
  };

  // Scoreboards for the wide/narrow sweeps: expected product queued at each accepting edge.
  always @(posedge clock) begin
    if (!rst2 && ready4 && start4) q4.push_back(refProduct(32'(a4), 32'(b4), sm4, 4));
    if (!rst2 && ready16 && start16) q16.push_back(refProduct(32'(a16), 32'(b16), sm16, 16));
  end

  always @(negedge clock) begin
    if (!rst2 && done4) begin
      if (q4.size() == 0) checkOutput("w4 empty", 64'd1, 64'd0);
      else checkOutput("w4 prod", 64'(product4), q4.pop_front());
      n4++;
    end
    if (!rst2 && done16) begin
      if (q16.size() == 0) checkOutput("w16 empty", 64'd1, 64'd0);
      else checkOutput("w16 prod", 64'(product16), q16.pop_front());
      n16++;
    end
  end

  initial begin
    rst2 = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clock);
    rst2 = 1'b0;
    for (int cyc = 0; cyc < 20000 && (n4 < 600 || n16 < 600); cyc++) begin
      start4 = 1'b1;
      start16 = 1'b1;
      sm4 = 1'($urandom);
      sm16 = 1'($urandom);
      a4 = ($urandom_range(0, 7) == 0) ? 4'h8 : 4'($urandom);
      b4 = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      a16 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clock);
    end
    start4 = 1'b0;
    start16 = 1'b0;
    sweepDone = 1'b1;
  end

  initial begin
    int n;
    int dones;
    logic [7:0] ra, rb;
    bit rs;
    reset = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    checkOutput("rst ready", 64'(ready8), 64'd1);
    checkOutput("rst busy", 64'(busy8), 64'd0);
    checkOutput("rst done", 64'(done8), 64'd0);
    checkOutput("rst prod", 64'(product8), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, 1'b0);

    applyStimulus("pulse", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      applyStimulus($sformatf("rnd%0d", i), ra, rb, rs, 16'(refProduct(32'(ra), 32'(rb), rs, 8)), 1'b0);
    end

    // Start held high: the second accept lands on the first IDLE cycle after DONE.
    @(negedge clock);
    a8 = 8'hB7; b8 = 8'hC5; sm8 = 1'b1; start8 = 1'b1;
    @(negedge clock);
    n = 0;
    while (!ready8 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("b2b interval", 64'(n + 1), 64'(refLatency(32'h0000_00C5, 1'b1, 8) + 1));
    checkOutput("b2b prod1", 64'(product8), refProduct(32'h0000_00B7, 32'h0000_00C5, 1'b1, 8));
    @(negedge clock);
    checkOutput("b2b accept2", 64'(busy8), 64'd1);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("b2b prod2", 64'(product8), refProduct(32'h0000_00B7, 32'h0000_00C5, 1'b1, 8));
    @(negedge clock);

    // Reset during the fourth CALC cycle abandons the operation.
    a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("mid busy pre", 64'(busy8), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid ready", 64'(ready8), 64'd1);
    checkOutput("mid busy", 64'(busy8), 64'd0);
    checkOutput("mid done", 64'(done8), 64'd0);
    checkOutput("mid prod", 64'(product8), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clock);
      if (done8) dones++;
    end
    checkOutput("mid nodone", 64'(dones), 64'd0);
    checkOutput("mid prod after", 64'(product8), 64'd0);

    applyStimulus("post rst", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);

    n = 0;
    while (!sweepDone && n < 25000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("sweep finished", 64'(sweepDone), 64'd1);
    repeat (40) @(negedge clock);
    checkOutput("w4 count", 64'(n4 >= 600), 64'd1);
    checkOutput("w16 count", 64'(n16 >= 600), 64'd1);
    checkOutput("w4 drained", 64'(q4.size()), 64'd0);
    checkOutput("w16 drained", 64'(q16.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_multiplier.md
PARAM_MULTIPLIER -- requirements
Module: param_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request to begin a multiply; sampled only when ready=1.
REQ-005 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands.
REQ-006 Port a  input  WIDTH  multiplicand; latched on start acceptance.
REQ-007 Port b  input  WIDTH  multiplier; latched on start acceptance.
REQ-008 Port ready  output  1  high only in IDLE; start accepted when start=1 and ready=1 at a rising edge.
REQ-009 Port busy  output  1  high only in CALC.
REQ-010 Port done  output  1  one-cycle pulse marking a valid product.
REQ-011 Port product  output  2*WIDTH  result; signed or unsigned per latched signed_mode.

Function
REQ-012 States: IDLE, CALC, DONE; exactly one active at any time.
REQ-013 IDLE -> CALC on the edge that accepts start; a, b, signed_mode latched on that edge.
REQ-014 Latch: signed_mode=1 stores |a|, |b| and sign flag a[MSB] XOR b[MSB]; signed_mode=0 stores a, b as-is with sign flag 0.
REQ-015 CALC: one multiplier bit per cycle, LSB first, shift-and-add into a 2*WIDTH accumulator.
REQ-016 CALC -> DONE after WIDTH CALC cycles; the final accumulator, two's-complement negated if sign flag=1, is registered into product on that edge.
REQ-017 Base latency: done high during the cycle beginning WIDTH+1 rising edges after the accepting edge.
REQ-018 DONE: done=1, ready=0, busy=0 for exactly one cycle, then unconditional return to IDLE.
REQ-019 product holds its value from DONE until the next DONE; it does not change during CALC.
REQ-020 start while in CALC or DONE is ignored; it is neither queued nor latched.
REQ-021 Magnitude of the most-negative operand (e.g. -128 at WIDTH=8) is 2^(WIDTH-1); the product is exact for all operand pairs, with no overflow or saturation.
REQ-022 Zero operands: the product is 0 and carries no sign, so -x*0 = 0.
REQ-023 Back-to-back: start held high is accepted again in the first IDLE cycle after DONE, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-024 Assertion of reset forces IDLE immediately, independent of clock.
REQ-025 Reset values: ready=1, busy=0, done=0, product=0; all internal accumulators, counters and latched operands cleared.
REQ-026 Reset mid-CALC abandons the operation; no done pulse follows and product reads 0.
REQ-027 First start acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MULT_EARLY_TERM_EN compiled in: CALC -> DONE occurs on the first CALC edge after which all remaining unprocessed bits of the latched magnitude of b are zero, with a minimum of 1 CALC cycle; the product is identical to the base mode.
REQ-029 Early-termination latency: done high in the cycle beginning max(1, p+1)+1 edges after acceptance, where p = index of the highest set bit of the latched magnitude of b (p = 0 when the magnitude is 0).
REQ-030 Macro absent: fixed WIDTH-cycle CALC per REQ-016/017, with no data-dependent latency.

Verification (WIDTH=8 unless stated)
REQ-031 Unsigned max: a=255, b=255, signed_mode=0 -> product=0xFE01, done in cycle 9 after accept, busy high 8 cycles.
REQ-032 Signed: a=0x80 (-128), b=0x80, signed_mode=1 -> product=0x4000; a=0xFD (-3), b=0x05 -> product=0xFFF1.
REQ-033 Ignored start and back-to-back: start pulsed during CALC -> no effect on result or timing; start held high -> second accept in the first IDLE cycle after DONE, interval 10 cycles.
REQ-034 Reset mid-op: reset asserted in the 4th CALC cycle -> ready=1, busy=0, product=0 immediately, with no done pulse.
REQ-035 With MULT_EARLY_TERM_EN: b=0x03, a=7 -> product=21, done 3 cycles after accept; b=0 -> product=0, done 2 cycles after accept. Without the macro, both take 9 cycles.
REQ-036 Random sweep at WIDTH=4 and WIDTH=16, both modes -> product matches the reference model for every operand pair, 1000+ vectors with no mismatches.
